// File: rtl/pc_control_unit_if.sv
// Fetch-side bundle for the program-counter unit: control requests in, PC and run status out.
// The slave modport is the PC unit itself; master is whoever drives hazard, branch and debug controls.
interface pc_control_unit_if #(
   parameter int NB       = 32,
   parameter int NB_COUNT = 32
);
   logic                i_enable;
   logic                i_stall;
   logic                i_mode_step;
   logic                i_step;
   logic                i_branch_taken;
   logic [NB-1:0]       i_branch_addr;
   logic                i_jump;
   logic [NB-1:0]       i_jump_addr;
   logic                i_halt;
   logic [NB-1:0]       o_pc;
   logic [NB-1:0]       o_pc_plus;
   logic                o_halted;
   logic                o_step_mode;
   logic [NB_COUNT-1:0] o_count;

   modport master (
      output i_enable, i_stall, i_mode_step, i_step, i_branch_taken, i_branch_addr,
             i_jump, i_jump_addr, i_halt,
      input  o_pc, o_pc_plus, o_halted, o_step_mode, o_count
   );

   modport slave (
      input  i_enable, i_stall, i_mode_step, i_step, i_branch_taken, i_branch_addr,
             i_jump, i_jump_addr, i_halt,
      output o_pc, o_pc_plus, o_halted, o_step_mode, o_count
   );
endinterface

// File: rtl/pc_control_unit.sv
// Program counter for the DLX fetch stage: next-PC selection, run/step/halt state
// and a saturating count of PC updates for the debug unit.
module pc_control_unit #(
   parameter int NB       = 32,
   parameter int PC_INC   = 1,
   parameter int RESET_PC = 0,
   parameter int NB_COUNT = 32
) (
   input  logic           i_clock,
   input  logic           i_reset,
   pc_control_unit_if.slave bus
);

   localparam logic [NB-1:0]       PC_INC_V   = NB'(PC_INC);
   localparam logic [NB-1:0]       RESET_PC_V = NB'(RESET_PC);
   localparam logic [NB_COUNT-1:0] COUNT_ONE  = NB_COUNT'(1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_STEP,
      ST_HALTED
   } state_t;

   state_t              state_q, state_d;
   logic [NB-1:0]       pc_q, pc_d;
   logic [NB_COUNT-1:0] count_q, count_d;
   logic                run_ok;
   logic                adv;
   logic                halt_evt;

   // A stalled or disabled cycle freezes everything, including pending mode changes.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      count_d  = count_q;
      halt_evt = 1'b0;

      run_ok = bus.i_enable && !bus.i_stall;
      adv    = run_ok && ((state_q == ST_RUN) || ((state_q == ST_STEP) && bus.i_step));

      if (adv) begin
         if (bus.i_branch_taken) begin
            pc_d = bus.i_branch_addr;
         end else if (bus.i_jump) begin
            pc_d = bus.i_jump_addr;
         end else if (bus.i_halt) begin
            halt_evt = 1'b1;
         end else begin
            pc_d = pc_q + PC_INC_V;
         end
         if (!halt_evt && (count_q != '1)) begin
            count_d = count_q + COUNT_ONE;
         end
      end

      // A redirect squashes a simultaneous halt, so only halt_evt can reach HALTED.
      case (state_q)
         ST_RUN: begin
            if (halt_evt) begin
               state_d = ST_HALTED;
            end else if (run_ok && bus.i_mode_step) begin
               state_d = ST_STEP;
            end
         end
         ST_STEP: begin
            if (halt_evt) begin
               state_d = ST_HALTED;
            end else if (run_ok && !bus.i_mode_step) begin
               state_d = ST_RUN;
            end
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC_V;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
      end
   end

   assign bus.o_pc        = pc_q;
   assign bus.o_pc_plus   = pc_q + PC_INC_V;
   assign bus.o_halted    = (state_q == ST_HALTED);
   assign bus.o_step_mode = (state_q == ST_STEP);
   assign bus.o_count     = count_q;

endmodule

// File: tb/tb_pc_control_unit.sv
// Drives two differently-parameterised PC units with the same control stream and
// compares every output against a flag-based reference model each cycle.
module tb_pc_control_unit;

   logic clk;
   logic rst;
   logic en, stall, ms, st, br, jp, hl;
   logic [15:0] baddr, jaddr;

   int checks;
   int fails;

   // Per-instance parameters: index 0 is the 8-bit wrap/saturation unit, 1 is the 16-bit offset unit.
   longint nbv   [2] = '{8, 16};
   longint incv  [2] = '{1, 4};
   longint rstv  [2] = '{0, 16'h0100};
   longint cmaxv [2] = '{15, 63};

   longint m_pc   [2];
   longint m_cnt  [2];
   bit     m_halt [2];
   bit     m_step [2];

   pc_control_unit_if #(.NB(8),  .NB_COUNT(4)) bus0 ();
   pc_control_unit_if #(.NB(16), .NB_COUNT(6)) bus1 ();

   assign bus0.i_enable       = en;
   assign bus0.i_stall        = stall;
   assign bus0.i_mode_step    = ms;
   assign bus0.i_step         = st;
   assign bus0.i_branch_taken = br;
   assign bus0.i_branch_addr  = baddr[7:0];
   assign bus0.i_jump         = jp;
   assign bus0.i_jump_addr    = jaddr[7:0];
   assign bus0.i_halt         = hl;

   assign bus1.i_enable       = en;
   assign bus1.i_stall        = stall;
   assign bus1.i_mode_step    = ms;
   assign bus1.i_step         = st;
   assign bus1.i_branch_taken = br;
   assign bus1.i_branch_addr  = baddr;
   assign bus1.i_jump         = jp;
   assign bus1.i_jump_addr    = jaddr;
   assign bus1.i_halt         = hl;

   pc_control_unit #(.NB(8), .PC_INC(1), .RESET_PC(0), .NB_COUNT(4)) dut0 (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus0)
   );

   pc_control_unit #(.NB(16), .PC_INC(4), .RESET_PC(16'h0100), .NB_COUNT(6)) dut1 (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference behaviour per instance, from the rules rather than any state encoding.
   task automatic modelTick(input int k);
      longint mask;
      bit     moved;
      mask  = (64'd1 << nbv[k]) - 1;
      moved = 1'b0;
      if (rst) begin
         m_pc[k]   = rstv[k];
         m_cnt[k]  = 0;
         m_halt[k] = 1'b0;
         m_step[k] = 1'b0;
         return;
      end
      if (!en || stall || m_halt[k]) return;
      if (!m_step[k] || st) begin
         if (br) begin
            m_pc[k] = longint'(baddr) & mask;
            moved   = 1'b1;
         end else if (jp) begin
            m_pc[k] = longint'(jaddr) & mask;
            moved   = 1'b1;
         end else if (hl) begin
            m_halt[k] = 1'b1;
         end else begin
            m_pc[k] = (m_pc[k] + incv[k]) & mask;
            moved   = 1'b1;
         end
         if (moved && m_cnt[k] < cmaxv[k]) m_cnt[k] = m_cnt[k] + 1;
      end
      m_step[k] = m_halt[k] ? 1'b0 : ms;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      longint mask0, mask1;
      mask0 = (64'd1 << nbv[0]) - 1;
      mask1 = (64'd1 << nbv[1]) - 1;
      check("u0_pc",      64'(bus0.o_pc),        m_pc[0]);
      check("u0_pc_plus", 64'(bus0.o_pc_plus),   (m_pc[0] + incv[0]) & mask0);
      check("u0_halted",  64'(bus0.o_halted),    64'(m_halt[0]));
      check("u0_step",    64'(bus0.o_step_mode), 64'(m_step[0]));
      check("u0_count",   64'(bus0.o_count),     m_cnt[0]);
      check("u1_pc",      64'(bus1.o_pc),        m_pc[1]);
      check("u1_pc_plus", 64'(bus1.o_pc_plus),   (m_pc[1] + incv[1]) & mask1);
      check("u1_halted",  64'(bus1.o_halted),    64'(m_halt[1]));
      check("u1_step",    64'(bus1.o_step_mode), 64'(m_step[1]));
      check("u1_count",   64'(bus1.o_count),     m_cnt[1]);
   endtask

   // One clock: model follows the inputs the DUTs sample, outputs checked just after the edge.
   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         modelTick(0);
         modelTick(1);
         #1;
         checkOutput();
      end
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      for (int k = 0; k < 2; k++) begin
         m_pc[k] = 0; m_cnt[k] = 0; m_halt[k] = 0; m_step[k] = 0;
      end
      rst = 1; en = 0; stall = 0; ms = 0; st = 0; br = 0; jp = 0; hl = 0;
      baddr = '0; jaddr = '0;

      $display("[TB] reset and run");
      applyStimulus(2);
      check("t1_reset_pc", 64'(bus0.o_pc), 64'd0);
      rst = 0; en = 1;
      applyStimulus(3);
      check("t1_pc3",     64'(bus0.o_pc),      64'd3);
      check("t1_count3",  64'(bus0.o_count),   64'd3);
      check("t1_pc_plus", 64'(bus0.o_pc_plus), 64'd4);

      $display("[TB] stall and disable");
      stall = 1;
      applyStimulus(2);
      check("t2_stall_pc", 64'(bus0.o_pc), 64'd3);
      stall = 0;
      applyStimulus(1);
      check("t2_release_pc", 64'(bus0.o_pc), 64'd4);
      en = 0;
      applyStimulus(2);
      check("t2_disable_cnt", 64'(bus0.o_count), 64'd4);
      en = 1;

      $display("[TB] redirect priority");
      br = 1; baddr = 16'h0040; jp = 1; jaddr = 16'h0080;
      applyStimulus(1);
      check("t3_branch_wins", 64'(bus0.o_pc), 64'h40);
      br = 0;
      applyStimulus(1);
      jp = 0;
      applyStimulus(1);
      check("t3_after_jump", 64'(bus0.o_pc), 64'h81);

      $display("[TB] step mode");
      ms = 1; st = 0;
      applyStimulus(5);
      st = 1;
      applyStimulus(1);
      st = 0;
      applyStimulus(2);
      ms = 0;
      applyStimulus(3);

      $display("[TB] halt");
      br = 1; baddr = 16'h0010;
      applyStimulus(1);
      br = 0; hl = 1;
      applyStimulus(1);
      check("t5_halt_pc", 64'(bus0.o_pc), 64'h10);
      check("t5_halted",  64'(bus0.o_halted), 64'd1);
      hl = 0; br = 1; baddr = 16'h0055;
      applyStimulus(1);
      br = 0; ms = 1; st = 1;
      applyStimulus(2);
      ms = 0; st = 0; rst = 1;
      applyStimulus(1);
      rst = 0; hl = 1; br = 1; baddr = 16'h0020;
      applyStimulus(1);
      check("t5_redirect_over_halt", 64'(bus0.o_pc), 64'h20);
      hl = 0; br = 0;

      $display("[TB] wrap and saturation");
      br = 1; baddr = 16'h00FD;
      applyStimulus(1);
      br = 0;
      applyStimulus(3);
      check("t6_wrap", 64'(bus0.o_pc), 64'h00);
      applyStimulus(20);
      check("t6_sat", 64'(bus0.o_count), 64'd15);

      $display("[TB] random traffic");
      for (int i = 0; i < 600; i++) begin
         rst   = ($urandom_range(0, 39) == 0);
         en    = ($urandom_range(0, 7) != 0);
         stall = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 15) == 0) ms = ~ms;
         st    = ($urandom_range(0, 2) == 0);
         br    = ($urandom_range(0, 7) == 0);
         jp    = ($urandom_range(0, 7) == 0);
         hl    = ($urandom_range(0, 24) == 0);
         baddr = 16'($urandom);
         jaddr = 16'($urandom);
         applyStimulus(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/pc_control_unit.md
Name: pc_control_unit

Overview:
Parametrised program-counter unit for the MIPS-DLX fetch stage. It holds the PC register and owns the next-PC selection: sequential increment, taken branch, jump, hazard stall, halt, and a debug single-step mode. It sits between the hazard/branch logic (ID/EX) and instruction memory. It reports PC, PC+increment, the run state and an advance counter to the debug unit.

Parameters:
NB, 32, PC and address width in bits
PC_INC, 1, increment added per sequential advance (1 = word-addressed instruction memory)
RESET_PC, 0, PC value loaded on reset
NB_COUNT, 32, width of advance counter

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  global run enable from debug unit; 0 freezes the block
i_stall  in  1  hazard stall; 1 blocks every PC update
i_mode_step  in  1  1 = single-step mode, 0 = continuous mode
i_step  in  1  one-cycle pulse; each cycle high in step mode permits one advance
i_branch_taken  in  1  taken branch redirect
i_branch_addr  in  NB  branch target
i_jump  in  1  jump redirect
i_jump_addr  in  NB  jump target
i_halt  in  1  halt instruction decoded
o_pc  out  NB  current PC (registered)
o_pc_plus  out  NB  o_pc + PC_INC, modulo 2^NB (combinational from o_pc)
o_halted  out  1  1 while in HALTED (registered)
o_step_mode  out  1  1 while in STEP (registered)
o_count  out  NB_COUNT  number of PC updates since reset

Behaviour:
- Reset, synchronous, on a rising edge with i_reset=1:
  - o_pc = RESET_PC
  - o_count = 0
  - state = RUN, so o_halted = 0 and o_step_mode = 0
  - Reset overrides every other input, including mid-halt and mid-step.
- States: RUN, STEP, HALTED.
  - RUN -> STEP when i_mode_step=1.
  - STEP -> RUN when i_mode_step=0.
  - RUN or STEP -> HALTED on a halt event (below).
  - HALTED is left only by reset. i_mode_step is ignored in HALTED.
  - Mode change takes effect the cycle after it is sampled.
- Advance condition (adv), evaluated each cycle:
  - Requires i_enable=1 and i_stall=0.
  - In RUN, that is sufficient.
  - In STEP, i_step=1 is also required.
  - In HALTED, adv = 0.
- When adv=1, next PC priority is:
  - i_branch_taken -> i_branch_addr
  - else i_jump -> i_jump_addr
  - else i_halt -> PC holds and state -> HALTED (halt event)
  - else o_pc + PC_INC
- Simultaneous events:
  - Branch or jump together with halt: the redirect wins, halt is ignored (the halt is on a squashed path) and no HALTED transition occurs.
  - Branch and jump together: branch wins.
- Stall:
  - i_stall=1 or i_enable=0 holds o_pc, o_count and state, and drops any redirect or halt.
  - Requesters must hold the request until it is accepted.
- Latency: one cycle. A redirect sampled on edge N appears on o_pc after edge N.
- o_count:
  - Increments by 1 on every adv cycle that updates the PC (sequential or redirect).
  - Does not increment on a halt event.
  - Saturates at 2^NB_COUNT-1.
- Width and alignment:
  - Increment wraps modulo 2^NB, with no overflow flag.
  - Targets are loaded unmodified, with no alignment check.

Test Plan:
1. Reset and run: i_reset=1 for 2 cycles (RESET_PC=0), then i_enable=1 for 3 cycles -> o_pc=0,count=0 during reset; then o_pc 1,2,3 and o_count=3; o_pc_plus=4.
2. Stall: at o_pc=3, i_stall=1 for 2 cycles -> o_pc stays 3 and o_count stays 3; release -> o_pc=4, o_count=4. Repeat with i_enable=0 -> same hold.
3. Redirect priority: i_branch_taken=1 (0x40) and i_jump=1 (0x80) in the same cycle -> o_pc=0x40; next cycle i_jump only (0x80) -> o_pc=0x80, then 0x81.
4. Step mode: i_mode_step=1, i_step=0 for 5 cycles -> o_step_mode=1 and o_pc unchanged; single i_step pulse -> o_pc+1 exactly once; i_mode_step=0 -> continuous advance resumes.
5. Halt:
   - i_halt=1 at o_pc=0x10 -> o_pc stays 0x10, o_halted=1 after the edge, o_count unchanged.
   - A following branch or step is ignored.
   - i_reset -> o_pc=RESET_PC, o_halted=0.
   - Separately, i_halt together with i_branch_taken (0x20) -> o_pc=0x20, o_halted=0.
6. Wrap and saturation: NB=8, NB_COUNT=4, o_pc reaches 0xFF -> next o_pc=0x00; after 16+ advances o_count holds at 15.
